// File: rtl/uart_tx_param.sv
// UART transmitter: a small FIFO feeding a frame-aligned baud FSM (start, data LSB first, parity, stop).
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_param #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               valid,
   input  logic [DATA_BITS-1:0]               data,
   output logic                               ready,
   input  logic                               parity_odd,
   output logic                               dout,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
   localparam int DIV    = CLK_FREQ / BAUD_RATE;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_reg;
   logic [BAUD_W-1:0]    baud_cnt_reg;
   logic [3:0]           bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 dout_reg;
   logic                 dout_next;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

   logic push;
   logic pop;
   logic fifo_empty;
   logic baud_end;
   logic frame_end;

`ifdef UART_TX_PARITY_EN
   logic parity_reg;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
`endif

   assign fifo_empty = (count_reg == '0);
   assign ready      = (count_reg < DEPTH_C);
   assign push       = valid && ready;
   assign baud_end   = (baud_cnt_reg == BAUD_LAST);
   assign frame_end  = (state_reg == STOP) && baud_end && (bit_cnt_reg == STOP_LAST);
   // A new frame starts straight from IDLE or from the last stop cycle, giving zero-gap back-to-back frames.
   assign pop        = !fifo_empty && ((state_reg == IDLE) || frame_end);

   assign dout       = dout_reg;
   assign busy       = (state_reg != IDLE) || !fifo_empty;
   assign fifo_count = count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= data;
      end
   end

   always_comb begin
      dout_next = 1'b1;
      case (state_reg)
         START:   dout_next = 1'b0;
         DATA:    dout_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  dout_next = parity_reg;
`endif
         default: dout_next = 1'b1;
      endcase
   end

   // The line is registered one cycle behind the state, so a word accepted into an idle
   // transmitter pulls the line low on the second edge after acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         dout_reg     <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         dout_reg <= dout_next;

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            shift_reg  <= fifo_mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
            parity_reg <= (^fifo_mem[rd_ptr_reg]) ^ parity_odd;
`endif
         end
         if (push && !pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - CNT_W'(1);
         end

         case (state_reg)
            IDLE: begin
               baud_cnt_reg <= '0;
               bit_cnt_reg  <= '0;
               if (pop) begin
                  state_reg <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  state_reg    <= DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  shift_reg    <= shift_reg >> 1;
                  if (bit_cnt_reg == DATA_LAST) begin
                     bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     state_reg   <= PARITY;
`else
                     state_reg   <= STOP;
`endif
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  state_reg    <= STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
               end
            end
`endif
            STOP: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  if (bit_cnt_reg == STOP_LAST) begin
                     bit_cnt_reg <= '0;
                     state_reg   <= pop ? START : IDLE;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
               end
            end
            default: begin
               baud_cnt_reg <= '0;
               bit_cnt_reg  <= '0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: scoreboard-checked frames on an 8N1 instance, plus a 7-bit/2-stop instance.
module tb_uart_tx_param;
   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int NB1 = 1 + 8 + PAR_EN + 1;
   localparam int NB2 = 1 + 7 + PAR_EN + 2;

   typedef struct { logic [7:0] d; logic po; logic exp_par; } vec_t;
   typedef struct { logic [7:0] d; logic exp_par; bit b2b; } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid1 = 1'b0;
   logic [7:0] data1 = '0;
   logic       po1 = 1'b0;
   logic       ready1, dout1, busy1;
   logic [2:0] cnt1;
   logic       valid2 = 1'b0;
   logic [6:0] data2 = '0;
   logic       po2 = 1'b0;
   logic       ready2, dout2, busy2;
   logic [2:0] cnt2;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_cnt = 0;
   exp_t exp_q[$];

   logic [15:0] mon_got;
   bit          mon_stable, mon_aborted;
   int          mon_start, mon_last_end = -100;
   exp_t        mon_e;

   uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1),
                   .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .valid(valid1), .data(data1), .ready(ready1),
      .parity_odd(po1), .dout(dout1), .busy(busy1), .fifo_count(cnt1));

   uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .valid(valid2), .data(data2), .ready(ready2),
      .parity_odd(po2), .dout(dout2), .busy(busy2), .fifo_count(cnt2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input int ns,
                                              input logic par);
      logic [15:0] f;
      int          k;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < nd; i++) f[1+i] = d[i];
      k = 1 + nd;
      if (PAR_EN != 0) begin
         f[k] = par;
         k++;
      end
      for (int i = k + ns; i < 16; i++) f[i] = 1'b0;
      return f;
   endfunction

   // Called at the negedge holding the first start-bit sample; samples every cycle of the frame.
   task automatic sample_frame(input bit sel, input int nbits, output logic [15:0] bits,
                               output bit stable, output bit aborted);
      logic first, cur;
      first   = 1'b1;
      stable  = 1'b1;
      aborted = 1'b0;
      bits    = '0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < DIV; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rst) begin
               aborted = 1'b1;
               return;
            end
            cur = sel ? dout2 : dout1;
            if (c == 0) first = cur;
            else if (cur !== first) stable = 1'b0;
         end
         bits[b] = first;
      end
   endtask

   task automatic drive_word(input logic [7:0] d, input logic po, input logic ep, input bit b2b);
      exp_t e;
      e.d = d;
      e.exp_par = ep;
      e.b2b = b2b;
      valid1 = 1'b1;
      data1  = d;
      po1    = po;
      exp_q.push_back(e);
      @(negedge clk);
      valid1 = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy1) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (n >= max_cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: got timeout after %0d cycles expected frames drained", n);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst && dout1 === 1'b0) begin
            mon_start = cyc_cnt;
            sample_frame(1'b0, NB1, mon_got, mon_stable, mon_aborted);
            if (!mon_aborted) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_frame: got bits %0h expected no frame", mon_got);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("frame_bits", 32'(mon_got), 32'(frame_bits({1'b0, mon_e.d}, 8, 1, mon_e.exp_par)));
                  check("bit_hold_div", 32'(mon_stable), 32'd1);
                  if (mon_e.b2b) check("interframe_gap", mon_start - mon_last_end - 1, 0);
                  $display("frame data=%02h bits=%04h", mon_e.d, mon_got);
               end
               mon_last_end = cyc_cnt;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t        tbl[8];
      vec_t        ff_tbl[5];
      logic [15:0] got2;
      bit          st2, ab2;
      int          n, zeros;

      tbl[0] = '{8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'h07, 1'b0, 1'b1};
      tbl[2] = '{8'h07, 1'b1, 1'b0};
      tbl[3] = '{8'h00, 1'b1, 1'b1};
      tbl[4] = '{8'hFF, 1'b0, 1'b0};
      tbl[5] = '{8'h3C, 1'b1, 1'b1};
      tbl[6] = '{8'h80, 1'b0, 1'b1};
      tbl[7] = '{8'h01, 1'b1, 1'b0};
      ff_tbl[0] = '{8'h11, 1'b0, 1'b0};
      ff_tbl[1] = '{8'h23, 1'b0, 1'b1};
      ff_tbl[2] = '{8'h34, 1'b0, 1'b1};
      ff_tbl[3] = '{8'h4F, 1'b0, 1'b1};
      ff_tbl[4] = '{8'h5E, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      check("rst_dout", dout1, 1);
      check("rst_ready", ready1, 1);
      check("rst_busy", busy1, 0);
      check("rst_count", cnt1, 0);
      check("rst_dout2", dout2, 1);
      #2 rst = 1'b0;
      @(negedge clk);

      // Start latency: line low exactly two edges after the accepting edge.
      drive_word(8'hA5, 1'b0, 1'b0, 1'b0);
      check("accept_count", cnt1, 1);
      check("accept_busy", busy1, 1);
      check("dout_edge0", dout1, 1);
      @(negedge clk);
      check("dout_edge1", dout1, 1);
      check("pop_count", cnt1, 0);
      @(negedge clk);
      check("dout_edge2", dout1, 0);
      wait_idle(300);
      check("idle_busy", busy1, 0);
      check("idle_dout", dout1, 1);

      for (int i = 0; i < 8; i++) begin
         drive_word(tbl[i].d, tbl[i].po, tbl[i].exp_par, 1'b0);
         wait_idle(300);
         check("tbl_idle_count", cnt1, 0);
      end

      // Data and parity mode are latched at pop; later input changes must not leak in.
      drive_word(8'h07, 1'b1, 1'b0, 1'b0);
      repeat (25) @(negedge clk);
      po1   = 1'b0;
      data1 = 8'hFF;
      wait_idle(300);

      // Fill the FIFO, then offer more words while full.
      for (int i = 0; i < 5; i++) drive_word(ff_tbl[i].d, ff_tbl[i].po, ff_tbl[i].exp_par, i > 0);
      check("full_ready", ready1, 0);
      check("full_count", cnt1, 4);
      valid1 = 1'b1;
      data1  = 8'hEE;
      repeat (3) @(negedge clk);
      check("full_ignore_count", cnt1, 4);
      check("full_ignore_ready", ready1, 0);
      valid1 = 1'b0;
      wait_idle(5 * NB1 * DIV + 100);

      // 7 data bits, 2 stop bits, two frames back to back.
      valid2 = 1'b1;
      data2  = 7'h55;
      po2    = 1'b0;
      @(negedge clk);
      data2 = 7'h2A;
      @(negedge clk);
      valid2 = 1'b0;
      @(negedge clk);
      check("dut2_start_latency", dout2, 0);
      sample_frame(1'b1, NB2, got2, st2, ab2);
      check("dut2_frame1", 32'(got2), 32'(frame_bits({2'b00, 7'h55}, 7, 2, 1'b0)));
      check("dut2_hold1", 32'(st2), 32'd1);
      $display("dut2 frame data=55 bits=%04h", got2);
      @(negedge clk);
      check("dut2_b2b_start", dout2, 0);
      sample_frame(1'b1, NB2, got2, st2, ab2);
      check("dut2_frame2", 32'(got2), 32'(frame_bits({2'b00, 7'h2A}, 7, 2, 1'b1)));
      check("dut2_hold2", 32'(st2), 32'd1);
      $display("dut2 frame data=2a bits=%04h", got2);
      n = 0;
      while (busy2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("dut2_idle_busy", busy2, 0);

      // Reset during the 4th data bit with a second word buffered.
      drive_word(8'hC3, 1'b0, 1'b0, 1'b0);
      drive_word(8'h5A, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (dout1 !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_start", dout1, 0);
      repeat (DIV * 4 + 5) @(negedge clk);
      check("rst_test_buffered", cnt1, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_dout", dout1, 1);
      check("midrst_count", cnt1, 0);
      check("midrst_ready", ready1, 1);
      check("midrst_busy", busy1, 0);
      check("midrst_count2", cnt2, 0);
      check("midrst_ready2", ready2, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      zeros = 0;
      repeat (300) begin
         @(negedge clk);
         if (dout1 !== 1'b1) zeros++;
      end
      check("post_rst_silent", zeros, 0);
      check("post_rst_busy", busy1, 0);
      drive_word(8'h96, 1'b1, 1'b1, 1'b0);
      wait_idle(300);
      check("final_count", cnt1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
